mux_nx1_serial: RTL and testbench
=================================

Name: mux_nx1_serial

Overview:
- Parametrised successor to the 4-lane byte mux; serialises one group of LANES parallel WIDTH-bit lane words onto a single WIDTH-bit output, one lane per clock.
- Uses a single clock with an internal lane counter instead of derived clk1f/clk2f/clk4f.
- Ready/valid intake allows gapless back-to-back groups.
- Sits in the PCIe physical-layer transmit path, between the lane-striped byte source and the serialiser/encoder.

Parameters:
- WIDTH, 8, bits per lane word.
- LANES, 4, number of input lanes; legal range 2..16.
- IDLE_WORD, 8'hBC, value driven on out_data when no lane word is emitted (K28.5 COM); width WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; 0 = in reset, sampled on rising clk.
- in_data  input  LANES*WIDTH  packed lane words; lane i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  LANES  per-lane valid for in_data.
- in_ready  output  1  combinational; block accepts a group this cycle.
- out_data  output  WIDTH  registered serialised lane word.
- out_valid  output  1  registered; out_data carries a real lane word.
- out_lane  output  clog2(LANES)  registered source lane index of out_data.

Behaviour:
- Reset (reset==0 at edge):
  - state<=IDLE; hold registers cleared; cnt<=0.
  - out_data<=IDLE_WORD, out_valid<=0, out_lane<=0.
  - in_ready forced 0 while reset==0.
- States are IDLE and SHIFT.
- in_ready = reset && (state==IDLE || (state==SHIFT && the lane emitted at the next edge is the last lane of the held group)).
  - Base build: last lane = cnt==LANES-1.
- Capture occurs at an edge when in_ready && |in_valid:
  - hold_data<=in_data, hold_valid<=in_valid, cnt<=first lane to emit, state<=SHIFT.
  - in_valid==0 with in_ready==1: no capture. Data is ignored.
- SHIFT, each edge:
  - out_data<=hold_data[cnt], out_valid<=hold_valid[cnt], out_lane<=cnt, then cnt advances.
  - A held lane with valid 0 drives out_data<=IDLE_WORD, out_valid<=0, out_lane<=cnt.
- Latency: group captured at edge T; lane 0 appears after edge T+1; lane i after edge T+1+i.
- Last-lane edge, simultaneous capture:
  - Hold is reloaded on the same edge its last lane is read (nonblocking).
  - The new lane 0 appears at the next edge, giving zero-bubble throughput of one group per LANES cycles.
- Last-lane edge, no capture: state<=IDLE. Next edge drives IDLE_WORD, out_valid=0.
- IDLE: out_data=IDLE_WORD, out_valid=0, out_lane holds 0.
- cnt wraps LANES-1 -> 0 only via capture; no overflow.
- Reset asserted mid-group: the group is discarded; no partial lanes are emitted after reset releases.
- in_data/in_valid changing while in_ready==0: ignored.

Optional Feature:
- Macro: MUX_SKIP_INVALID_EN.
- Defined:
  - Lanes with hold_valid==0 are skipped, not emitted.
  - Capture sets cnt to the lowest valid lane; cnt advances to the next higher valid lane.
  - "Last lane" is the highest-index valid lane, so a group takes popcount(in_valid) cycles.
  - out_valid is always 1 in SHIFT.
- Undefined: every lane slot is emitted as described in Behaviour; fixed LANES cycles per group.

Decomposition:
- Shared include file mux_defs.vh:
  - IDLE_WORD default (8'hBC).
  - IDLE/SHIFT state encodings.
  - Lane-index width macro (clog2).
- One natural sub-module, lane_pick (combinational):
  - Given hold_valid and cnt, returns the next lane index and an is_last flag.
  - Also extracts hold_data[cnt].
  - Trivial when MUX_SKIP_INVALID_EN is undefined.

Test Plan:
- (LANES=4, WIDTH=8.)
- Reset: hold reset=0 for 2 cycles with in_valid=4'hF -> out_data=8'hBC, out_valid=0, in_ready=0. Release -> in_ready=1.
- Single group: in_data={8'h44,8'h33,8'h22,8'h11}, in_valid=4'hF, captured at edge T -> outputs 11,22,33,44 with out_lane 0..3 at T+1..T+4. BC with out_valid=0 from T+5.
- Back-to-back: present group B=AA,BB,CC,DD when in_ready rises at cnt==3 -> 11,22,33,44,AA,BB,CC,DD on 8 consecutive cycles, no bubble.
- Partial valid: in_valid=4'b0101, macro off -> 11,BC(v=0),33,BC(v=0). Macro on -> 11 (lane 0), 33 (lane 2) in 2 cycles; in_ready high the cycle before 33.
- Reset mid-group: reset=0 at edge T+2 -> out_data=BC, out_valid=0 from T+3. After release no 33/44 appear.
- Stall: in_valid=0 while idle for 10 cycles -> no capture, out_valid stays 0, out_data=BC.

Source files
------------

// File: rtl/mux_nx1_serial_pkg.sv
// rtl/mux_nx1_serial_pkg.sv - shared defaults and state encoding for the lane serialiser
// Optional feature macro: MUX_SKIP_INVALID_EN (skip lanes whose valid bit is low).
package mux_nx1_serial_pkg;

  // K28.5 comma, the 8-bit default filler for idle slots
  localparam logic [7:0] IDLE_WORD_DEF = 8'hBC;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/mux_nx1_serial_lane_pick.sv
// rtl/mux_nx1_serial_lane_pick.sv - selects the held lane word and computes the next lane / last flag
// With MUX_SKIP_INVALID_EN defined, lanes with a clear valid bit are skipped.
module lane_pick #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int LW    = $clog2(LANES)
) (
  input  logic [LANES*WIDTH-1:0] hold_data,
  input  logic [LANES-1:0]       hold_valid,
  input  logic [LW-1:0]          cnt,
  output logic [WIDTH-1:0]       lane_data,
  output logic                   lane_valid,
  output logic [LW-1:0]          next_lane,
  output logic                   is_last
);

  always_comb begin
    lane_data  = '0;
    lane_valid = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (cnt == LW'(i)) begin
        lane_data  = hold_data[i*WIDTH +: WIDTH];
        lane_valid = hold_valid[i];
      end
    end
  end

`ifdef MUX_SKIP_INVALID_EN
  // Scan downward so the lowest valid lane above cnt wins
  always_comb begin
    next_lane = cnt;
    is_last   = 1'b1;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (hold_valid[i] && (i > int'(cnt))) begin
        next_lane = LW'(i);
        is_last   = 1'b0;
      end
    end
  end
`else
  always_comb begin
    next_lane = cnt + LW'(1);
    is_last   = (int'(cnt) == LANES - 1);
  end
`endif

endmodule

// File: rtl/mux_nx1_serial.sv
// rtl/mux_nx1_serial.sv - serialises a group of LANES lane words onto one output, one lane per clock
// Optional feature macro: MUX_SKIP_INVALID_EN (emit only valid lanes).
module mux_nx1_serial
  import mux_nx1_serial_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter int                 LANES     = 4,
  parameter logic [WIDTH-1:0]   IDLE_WORD = WIDTH'(IDLE_WORD_DEF)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [LANES*WIDTH-1:0]     in_data,
  input  logic [LANES-1:0]           in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic [$clog2(LANES)-1:0]   out_lane
);

  localparam int LW = $clog2(LANES);

  state_t                 state, state_next;
  logic [LW-1:0]          cnt, cnt_next;
  logic [LANES*WIDTH-1:0] hold_data;
  logic [LANES-1:0]       hold_valid;
  logic [WIDTH-1:0]       lane_data;
  logic                   lane_valid;
  logic [LW-1:0]          next_lane;
  logic                   is_last;
  logic [LW-1:0]          first_lane;
  logic                   capture;

  lane_pick #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .LW    (LW)
  ) u_lane_pick (
    .hold_data  (hold_data),
    .hold_valid (hold_valid),
    .cnt        (cnt),
    .lane_data  (lane_data),
    .lane_valid (lane_valid),
    .next_lane  (next_lane),
    .is_last    (is_last)
  );

`ifdef MUX_SKIP_INVALID_EN
  always_comb begin
    first_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (in_valid[i]) first_lane = LW'(i);
    end
  end
`else
  assign first_lane = '0;
`endif

  // Ready on the final lane lets the next group load with no bubble
  assign in_ready = reset && ((state == ST_IDLE) || ((state == ST_SHIFT) && is_last));
  assign capture  = in_ready && (|in_valid);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (capture) begin
      state_next = ST_SHIFT;
      cnt_next   = first_lane;
    end else if (state == ST_SHIFT) begin
      if (is_last) begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end else begin
        cnt_next = next_lane;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      hold_data  <= '0;
      hold_valid <= '0;
      out_data   <= IDLE_WORD;
      out_valid  <= 1'b0;
      out_lane   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        hold_data  <= in_data;
        hold_valid <= in_valid;
      end
      if (state == ST_SHIFT) begin
        out_data  <= lane_valid ? lane_data : IDLE_WORD;
        out_valid <= lane_valid;
        out_lane  <= cnt;
      end else begin
        out_data  <= IDLE_WORD;
        out_valid <= 1'b0;
        out_lane  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_serial.sv
// tb/tb_mux_nx1_serial.sv - directed self-checking bench for mux_nx1_serial (LANES=4, WIDTH=8)
// Honours MUX_SKIP_INVALID_EN when the design is built with it.
module tb_mux_nx1_serial;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_lane;

  int n_checks;
  int n_fail;

  mux_nx1_serial #(
    .WIDTH     (8),
    .LANES     (4),
    .IDLE_WORD (8'hBC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_lane  (out_lane)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    in_valid = 4'hF;
    in_data  = 32'hDEADBEEF;
    step();
    step();
    n_checks++;
    if (out_data !== 8'hBC) begin
      n_fail++; $display("FAIL reset_out_data got %h want bc", out_data);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready);
    end
    in_valid = 4'h0;
    reset    = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_in_ready got %b want 1", in_ready);
    end
    step();
  endtask

  task automatic test_single();
    logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid = 4'hF;
    step();
    in_valid = 4'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (out_data !== exp_d[i] || out_valid !== 1'b1 || out_lane !== 2'(i)) begin
        n_fail++;
        $display("FAIL single_lane%0d got d=%h v=%b l=%0d want d=%h v=1 l=%0d",
                 i, out_data, out_valid, out_lane, exp_d[i], i);
      end
    end
    step();
    n_checks++;
    if (out_data !== 8'hBC || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_tail got d=%h v=%b want d=bc v=0", out_data, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid = 4'hF;
    step();
    in_valid = 4'h0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("FAIL b2b_mid_ready got %b want 0", in_ready);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_last_ready got %b want 1", in_ready);
        end
        in_data  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        in_valid = 4'hF;
      end
      step();
      if (i == 3) in_valid = 4'h0;
      n_checks++;
      if (out_data !== exp_d[i] || out_valid !== 1'b1 || out_lane !== 2'(i % 4)) begin
        n_fail++;
        $display("FAIL b2b_word%0d got d=%h v=%b l=%0d want d=%h v=1 l=%0d",
                 i, out_data, out_valid, out_lane, exp_d[i], i % 4);
      end
    end
    step();
    n_checks++;
    if (out_data !== 8'hBC || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_tail got d=%h v=%b want d=bc v=0", out_data, out_valid);
    end
  endtask

  task automatic test_partial();
`ifdef MUX_SKIP_INVALID_EN
    logic [7:0] exp_d [3] = '{8'h11, 8'h33, 8'hBC};
    logic       exp_v [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] exp_l [3] = '{2'd0, 2'd2, 2'd0};
    int         n = 3;
`else
    logic [7:0] exp_d [5] = '{8'h11, 8'hBC, 8'h33, 8'hBC, 8'hBC};
    logic       exp_v [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] exp_l [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    int         n = 5;
`endif
    in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid = 4'b0101;
    step();
    in_valid = 4'h0;
    for (int i = 0; i < n; i++) begin
      step();
      n_checks++;
      if (out_data !== exp_d[i] || out_valid !== exp_v[i] || out_lane !== exp_l[i]) begin
        n_fail++;
        $display("FAIL partial_slot%0d got d=%h v=%b l=%0d want d=%h v=%b l=%0d",
                 i, out_data, out_valid, out_lane, exp_d[i], exp_v[i], exp_l[i]);
      end
`ifdef MUX_SKIP_INVALID_EN
      if (i == 0) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++; $display("FAIL partial_skip_ready got %b want 1", in_ready);
        end
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid = 4'hF;
    step();
    in_valid = 4'h0;
    step();
    step();
    n_checks++;
    if (out_data !== 8'h22 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pre got d=%h v=%b want d=22 v=1", out_data, out_valid);
    end
    reset = 1'b0;
    step();
    n_checks++;
    if (out_data !== 8'hBC || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_in_reset got d=%h v=%b r=%b want d=bc v=0 r=0", out_data, out_valid, in_ready);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (out_data !== 8'hBC || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rmid_after%0d got d=%h v=%b want d=bc v=0", i, out_data, out_valid);
      end
    end
  endtask

  task automatic test_stall();
    in_valid = 4'h0;
    for (int i = 0; i < 10; i++) begin
      in_data = $urandom;
      step();
      n_checks++;
      if (out_data !== 8'hBC || out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stall%0d got d=%h v=%b r=%b want d=bc v=0 r=1", i, out_data, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    in_data  = '0;
    in_valid = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_partial();
    test_reset_mid();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
